// File: rtl/bws_pkg.sv
// rtl/bws_pkg.sv - shared types and width helper for the banked weight streamer
package bws_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      LAST = 2'd2
   } state_t;

   // Global row address width; never narrower than one bit.
   function automatic int calc_addr_w(input int nbanks, input int depth);
      return (nbanks * depth > 1) ? $clog2(nbanks * depth) : 1;
   endfunction

endpackage

// File: rtl/weight_rom_bank.sv
// rtl/weight_rom_bank.sv - one combinational weight ROM bank, address in, NUM-lane row out
module weight_rom_bank
   import bws_pkg::*;
#(
   parameter int    WIDTH       = 16,
   parameter int    NUM         = 128,
   parameter int    BANK_DEPTH  = 256,
   parameter string INIT_PREFIX = "",
   parameter int    BANK_ID     = 0,
   parameter int    AW          = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1
) (
   input  logic [AW-1:0]    addr,
   output logic [WIDTH-1:0] row [0:NUM-1]
);

   // Lane l of global row a holds a*NUM + l.
   always_comb begin
      for (int l = 0; l < NUM; l++) begin
         row[l] = WIDTH'((BANK_ID * BANK_DEPTH + int'(addr)) * NUM + l);
      end
   end

endmodule

// File: rtl/banked_weight_streamer.sv
// rtl/banked_weight_streamer.sv - walks a row range across ROM banks, one registered row per beat
module banked_weight_streamer
   import bws_pkg::*;
#(
   parameter int    WIDTH       = 16,
   parameter int    NUM         = 128,
   parameter int    BANK_DEPTH  = 256,
   parameter int    NBANKS      = 2,
   parameter int    ADDR        = calc_addr_w(NBANKS, BANK_DEPTH),
   parameter string INIT_PREFIX = "fire5_expand3"
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [ADDR-1:0]  base_addr,
   input  logic [ADDR:0]    row_count,
   output logic             busy,
   output logic             done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data [0:NUM-1],
   output logic             out_last
);

   localparam int LOG_DEPTH = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
   localparam int TOTAL     = NBANKS * BANK_DEPTH;
   localparam logic [ADDR:0] ONE_ROW = (ADDR+1)'(1);

   state_t            state_q, state_d;
   logic [ADDR-1:0]   cur_addr_q, cur_addr_d;
   logic [ADDR:0]     remaining_q, remaining_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic              done_q, done_d;
   logic [WIDTH-1:0]  out_data_q [0:NUM-1];
   logic [WIDTH-1:0]  out_data_d [0:NUM-1];

   logic [WIDTH-1:0]  bank_rows [0:NBANKS-1][0:NUM-1];
   logic [WIDTH-1:0]  sel_row [0:NUM-1];
   logic [LOG_DEPTH-1:0] local_row;
   logic [31:0]       bank_sel;
   logic              accept;
   logic              load;
   logic              cmd_start;
   logic              cmd_empty;

   assign local_row = LOG_DEPTH'(32'(cur_addr_q) % BANK_DEPTH);
   assign bank_sel  = 32'(cur_addr_q) / BANK_DEPTH;

   for (genvar b = 0; b < NBANKS; b++) begin : g_bank
      weight_rom_bank #(
         .WIDTH       (WIDTH),
         .NUM         (NUM),
         .BANK_DEPTH  (BANK_DEPTH),
         .INIT_PREFIX (INIT_PREFIX),
         .BANK_ID     (b),
         .AW          (LOG_DEPTH)
      ) u_bank (
         .addr (local_row),
         .row  (bank_rows[b])
      );
   end

   always_comb begin
      sel_row = bank_rows[0];
      for (int b = 0; b < NBANKS; b++) begin
         if (bank_sel == 32'(b)) sel_row = bank_rows[b];
      end
   end

   assign accept    = out_valid_q && out_ready;
   assign load      = (state_q == RUN) && (!out_valid_q || out_ready);
   assign cmd_start = (state_q == IDLE) && start && (row_count != '0);
   assign cmd_empty = (state_q == IDLE) && start && (row_count == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         for (int l = 0; l < NUM; l++) out_data_q[l] <= '0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
         out_data_q  <= out_data_d;
      end
   end

   // LAST is left only on the done cycle, so a start coinciding with done is ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cmd_start) state_d = RUN;
         RUN:     if (load && remaining_q == ONE_ROW) state_d = LAST;
         LAST:    if (done_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      done_d      = cmd_empty || ((state_q == LAST) && accept);

      if (accept) out_valid_d = 1'b0;

      if (cmd_start) begin
         cur_addr_d  = base_addr;
         remaining_d = row_count;
      end

      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_row;
         out_last_d  = (remaining_q == ONE_ROW);
         cur_addr_d  = (32'(cur_addr_q) == TOTAL - 1) ? '0 : cur_addr_q + ADDR'(1);
         remaining_d = remaining_q - ONE_ROW;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_banked_weight_streamer.sv
// tb/tb_banked_weight_streamer.sv - scoreboard bench for banked_weight_streamer
module tb_banked_weight_streamer;

   localparam int WIDTH = 16;
   localparam int NUM   = 128;
   localparam int DEPTH = 256;
   localparam int NB    = 2;
   localparam int AW    = 9;
   localparam int TOTAL = NB * DEPTH;

   typedef struct {
      int addr;
      bit last;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [AW-1:0]    base_addr = '0;
   logic [AW:0]      row_count = '0;
   logic             busy, done, out_valid, out_last;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] out_data [0:NUM-1];

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   beats = 0;
   bit   mon_en = 1'b0;
   bit   ready_rand = 1'b0;
   bit   done_due = 1'b0;
   bit   zc_flag = 1'b0;

   banked_weight_streamer #(
      .WIDTH(WIDTH), .NUM(NUM), .BANK_DEPTH(DEPTH), .NBANKS(NB), .INIT_PREFIX("")
   ) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .row_count(row_count),
      .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Monitor: every presented beat is compared against the head of the expectation queue.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         chk("done_timing", {31'd0, done}, {31'd0, done_due});
         done_due = 1'b0;
         if (zc_flag) begin
            done_due = 1'b1;
            zc_flag  = 1'b0;
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
               exp_t e;
               int   bad_lane;
               e = exp_q[0];
               bad_lane = -1;
               for (int l = 0; l < NUM; l++) begin
                  if (bad_lane < 0 && out_data[l] !== WIDTH'(e.addr * NUM + l)) bad_lane = l;
               end
               if (bad_lane < 0) chk("row_data", 32'd0, 32'd0 + 32'(bad_lane < 0 ? 0 : 1));
               else chk($sformatf("row_data row %0d lane %0d", e.addr, bad_lane),
                        32'(out_data[bad_lane]), 32'(WIDTH'(e.addr * NUM + bad_lane)));
               chk("out_last", {31'd0, out_last}, {31'd0, e.last});
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  beats++;
                  if (e.last) done_due = 1'b1;
               end
            end
         end
      end
   end

   task automatic push_cmd(input int base, input int cnt);
      for (int k = 0; k < cnt; k++) begin
         exp_t e;
         e.addr = (base + k) % TOTAL;
         e.last = (k == cnt - 1);
         exp_q.push_back(e);
      end
      if (cnt == 0) zc_flag = 1'b1;
   endtask

   task automatic issue(input int base, input int cnt);
      @(posedge clk); #1;
      start = 1'b1; base_addr = AW'(base); row_count = (AW+1)'(cnt);
      push_cmd(base, cnt);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      chk({name, "_done_seen"}, {31'd0, seen}, 32'd1);
      chk({name, "_all_beats"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
      $fatal(1);
   end

   initial begin
      int b0;
      rst = 1'b1; start = 1'b1; base_addr = 9'd250; row_count = 10'd10;
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rst_valid", {31'd0, out_valid}, 32'd0);
         chk("rst_busy", {31'd0, busy}, 32'd0);
         chk("rst_done", {31'd0, done}, 32'd0);
      end
      chk("rst_last", {31'd0, out_last}, 32'd0);
      chk("rst_data0", 32'(out_data[0]), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      mon_en = 1'b1;

      // Back-to-back stream across the bank boundary, then start-on-done and start-after-done.
      @(posedge clk); #1;
      start = 1'b1; base_addr = 9'd250; row_count = 10'd10;
      push_cmd(250, 10);
      @(negedge clk);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("latency_t1_valid", {31'd0, out_valid}, 32'd0);
      chk("latency_t1_busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stream_no_gap", {31'd0, out_valid}, 32'd1);
      end
      @(posedge clk); #1;
      start = 1'b1; base_addr = 9'd0; row_count = 10'd3;
      @(negedge clk);
      chk("done_after_last", {31'd0, done}, 32'd1);
      chk("valid_cleared", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      start = 1'b1; base_addr = 9'd510; row_count = 10'd4;
      push_cmd(510, 4);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("wrap", 40);

      // Random backpressure with a start pulse while busy.
      ready_rand = 1'b1;
      b0 = beats;
      issue(0, 64);
      repeat (10) @(posedge clk);
      #1;
      start = 1'b1; base_addr = 9'd100; row_count = 10'd5;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("random", 2000);
      chk("random_beat_count", 32'(beats - b0), 32'd64);
      ready_rand = 1'b0;

      issue(7, 0);
      wait_done("zero_count", 5);
      repeat (3) @(posedge clk);

      // Reset mid-stream after the third accepted beat.
      b0 = beats;
      issue(300, 20);
      for (int i = 0; i < 50 && beats - b0 < 3; i++) @(negedge clk);
      chk("mid_rst_three_beats", 32'(beats - b0), 32'd3);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      done_due = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      repeat (4) @(negedge clk);
      ready_rand = 1'b1;
      issue(40, 5);
      wait_done("after_rst", 200);
      ready_rand = 1'b0;

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
